// File: rtl/mesi_isc_mon_pkg.sv
// MESI ISC bus monitor: command encodings, error codes and per-core states.
// Shared by mesi_isc_mon_core and mesi_isc_bus_monitor.
package mesi_isc_mon_pkg;

    localparam int MBUS_NOP      = 0;
    localparam int MBUS_WR       = 1;
    localparam int MBUS_RD       = 2;
    localparam int MBUS_WR_BROAD = 3;
    localparam int MBUS_RD_BROAD = 4;

    localparam int CBUS_NOP      = 0;
    localparam int CBUS_WR_SNOOP = 1;
    localparam int CBUS_RD_SNOOP = 2;
    localparam int CBUS_EN_WR    = 3;
    localparam int CBUS_EN_RD    = 4;

    localparam int N_ERR_CODES = 7;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_ILL_MBUS    = 3'd1,
        ERR_ILL_CBUS    = 3'd2,
        ERR_ACK_STUCK   = 3'd3,
        ERR_WR_CONFLICT = 3'd4,
        ERR_TIMEOUT     = 3'd5,
        ERR_SPURIOUS_EN = 3'd6
    } err_code_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_ACK = 2'd1,
        ST_WAIT_EN  = 2'd2
    } core_state_e;

endpackage

// File: rtl/mesi_isc_mon_core.sv
// Per-core broadcast tracker and local error detection.
// MESI_ISC_MON_TIMEOUT_EN adds a per-core request timeout counter.
module mesi_isc_mon_core
    import mesi_isc_mon_pkg::*;
#(
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
    input  logic                      mbus_ack_i,
    input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
    output logic                      pending_o,
    output logic [N_ERR_CODES-1:0]    err_o
);

    localparam logic [MBUS_CMD_WIDTH-1:0] M_WRB = MBUS_CMD_WIDTH'(MBUS_WR_BROAD);
    localparam logic [MBUS_CMD_WIDTH-1:0] M_RDB = MBUS_CMD_WIDTH'(MBUS_RD_BROAD);
    localparam logic [CBUS_CMD_WIDTH-1:0] C_ENW = CBUS_CMD_WIDTH'(CBUS_EN_WR);
    localparam logic [CBUS_CMD_WIDTH-1:0] C_ENR = CBUS_CMD_WIDTH'(CBUS_EN_RD);

    core_state_e state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic        ack_q;
    logic        bcast, en_wr, en_rd, en_any, en_match;
    logic        ill_mbus, ill_cbus, ack_stuck;
    logic        spurious, timeout;

    assign bcast     = (mbus_cmd_i == M_WRB) || (mbus_cmd_i == M_RDB);
    assign en_wr     = (cbus_cmd_i == C_ENW);
    assign en_rd     = (cbus_cmd_i == C_ENR);
    assign en_any    = en_wr || en_rd;
    assign en_match  = is_wr_q ? en_wr : en_rd;
    assign ill_mbus  = (mbus_cmd_i > M_RDB);
    assign ill_cbus  = (cbus_cmd_i > C_ENR);
    assign ack_stuck = mbus_ack_i && ack_q;

`ifdef MESI_ISC_MON_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    assign cnt_inc = cnt_q + CNT_W'(1);
`endif

    always_comb begin
        state_d  = state_q;
        is_wr_d  = is_wr_q;
        spurious = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en_any) begin
                    spurious = 1'b1;
                end else if (bcast) begin
                    is_wr_d = (mbus_cmd_i == M_WRB);
                    state_d = mbus_ack_i ? ST_WAIT_EN : ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (en_any) begin
                    spurious = 1'b1;
                    state_d  = ST_IDLE;
                end else if (mbus_ack_i) begin
                    state_d = ST_WAIT_EN;
                end
            end
            ST_WAIT_EN: begin
                if (en_any) begin
                    spurious = !en_match;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef MESI_ISC_MON_TIMEOUT_EN
        // A request that completes in its final allowed cycle is not a timeout.
        if (state_q != ST_IDLE && state_d != ST_IDLE &&
            cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
            timeout = 1'b1;
            state_d = ST_IDLE;
        end
        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            is_wr_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            is_wr_q <= is_wr_d;
            ack_q   <= mbus_ack_i;
        end
    end

`ifdef MESI_ISC_MON_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign pending_o = (state_q != ST_IDLE);
    assign err_o     = {spurious, timeout, 1'b0, ack_stuck,
                        ill_cbus, ill_mbus, 1'b0};

endmodule

// File: rtl/mesi_isc_bus_monitor.sv
// MESI ISC bus protocol monitor: write-conflict check, error priority, sticky state.
// MESI_ISC_MON_TIMEOUT_EN enables per-core broadcast timeouts.
module mesi_isc_bus_monitor
    import mesi_isc_mon_pkg::*;
#(
    parameter int N_CORES        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [N_CORES*MBUS_CMD_WIDTH-1:0]  mbus_cmd_i,
    input  logic [N_CORES*ADDR_WIDTH-1:0]      mbus_addr_i,
    input  logic [N_CORES-1:0]                 mbus_ack_i,
    input  logic [N_CORES*CBUS_CMD_WIDTH-1:0]  cbus_cmd_i,
    input  logic [N_CORES-1:0]                 cbus_ack_i,
    input  logic                               clear_i,
    output logic                               err_valid_o,
    output logic [2:0]                         err_code_o,
    output logic [2:0]                         err_core_o,
    output logic [2:0]                         err_first_code_o,
    output logic [7:0]                         err_count_o,
    output logic [N_CORES-1:0]                 pending_o
);

    localparam int MW = MBUS_CMD_WIDTH;
    localparam int CW = CBUS_CMD_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam logic [MW-1:0] M_WR = MW'(MBUS_WR);

    logic [N_ERR_CODES-1:0] core_err [N_CORES];
    logic [N_ERR_CODES-1:0] err_all  [N_CORES];
    logic [N_CORES-1:0]     conflict;

    logic       found;
    err_code_e  code_sel;
    logic [2:0] core_sel;

    logic       err_valid_q;
    err_code_e  err_code_q;
    logic [2:0] err_core_q;
    err_code_e  first_q, first_d;
    logic [7:0] count_q, count_d;

    for (genvar k = 0; k < N_CORES; k++) begin : g_core
        mesi_isc_mon_core #(
            .MBUS_CMD_WIDTH(MW),
            .CBUS_CMD_WIDTH(CW),
            .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_core (
            .clk       (clk),
            .rst       (rst),
            .mbus_cmd_i(mbus_cmd_i[k*MW +: MW]),
            .mbus_ack_i(mbus_ack_i[k]),
            .cbus_cmd_i(cbus_cmd_i[k*CW +: CW]),
            .pending_o (pending_o[k]),
            .err_o     (core_err[k])
        );
    end

    // Conflicts are charged to the higher-indexed core of each matching pair.
    always_comb begin
        conflict = '0;
        for (int j = 1; j < N_CORES; j++) begin
            for (int i = 0; i < j; i++) begin
                if (mbus_cmd_i[j*MW +: MW] == M_WR &&
                    mbus_cmd_i[i*MW +: MW] == M_WR &&
                    mbus_addr_i[j*AW +: AW] == mbus_addr_i[i*AW +: AW]) begin
                    conflict[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_CORES; k++) begin
            err_all[k] = core_err[k];
            err_all[k][ERR_WR_CONFLICT] = conflict[k];
        end
    end

    always_comb begin
        found    = 1'b0;
        code_sel = ERR_NONE;
        core_sel = '0;
        for (int k = 0; k < N_CORES; k++) begin
            for (int c = 1; c < N_ERR_CODES; c++) begin
                if (!found && err_all[k][c]) begin
                    found    = 1'b1;
                    code_sel = err_code_e'(3'(c));
                    core_sel = 3'(k);
                end
            end
        end
    end

    // A clear and an error in the same cycle restart the sticky state from that error.
    always_comb begin
        first_d = first_q;
        count_d = count_q;
        if (clear_i) begin
            first_d = ERR_NONE;
            count_d = '0;
        end
        if (found) begin
            if (count_d != 8'hFF) begin
                count_d = count_d + 8'd1;
            end
            if (first_d == ERR_NONE) begin
                first_d = code_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_core_q  <= '0;
            first_q     <= ERR_NONE;
            count_q     <= '0;
        end else begin
            err_valid_q <= found;
            err_code_q  <= code_sel;
            err_core_q  <= core_sel;
            first_q     <= first_d;
            count_q     <= count_d;
        end
    end

    assign err_valid_o      = err_valid_q;
    assign err_code_o       = err_code_q;
    assign err_core_o       = err_core_q;
    assign err_first_code_o = first_q;
    assign err_count_o      = count_q;

    logic unused_cbus_ack;
    assign unused_cbus_ack = ^cbus_ack_i;

endmodule

// File: tb/tb_mesi_isc_bus_monitor.sv
// Scoreboard bench for mesi_isc_bus_monitor (4 cores, TIMEOUT_CYCLES=8).
// Timeout expectations follow MESI_ISC_MON_TIMEOUT_EN.
module tb_mesi_isc_bus_monitor;

    localparam int N  = 4;
    localparam int AW = 32;

    logic            clk;
    logic            rst;
    logic [N*3-1:0]  mbus_cmd_i;
    logic [N*AW-1:0] mbus_addr_i;
    logic [N-1:0]    mbus_ack_i;
    logic [N*3-1:0]  cbus_cmd_i;
    logic [N-1:0]    cbus_ack_i;
    logic            clear_i;
    logic            err_valid_o;
    logic [2:0]      err_code_o;
    logic [2:0]      err_core_o;
    logic [2:0]      err_first_code_o;
    logic [7:0]      err_count_o;
    logic [N-1:0]    pending_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic            rst;
        logic            clr;
        logic [N*3-1:0]  mcmd;
        logic [N*AW-1:0] maddr;
        logic [N-1:0]    mack;
        logic [N*3-1:0]  ccmd;
    } stim_t;

    stim_t       sq[$];
    logic [21:0] exp_q[$];

    mesi_isc_bus_monitor #(
        .N_CORES(N), .ADDR_WIDTH(AW), .MBUS_CMD_WIDTH(3),
        .CBUS_CMD_WIDTH(3), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mbus_cmd_i(mbus_cmd_i), .mbus_addr_i(mbus_addr_i),
        .mbus_ack_i(mbus_ack_i), .cbus_cmd_i(cbus_cmd_i),
        .cbus_ack_i(cbus_ack_i), .clear_i(clear_i),
        .err_valid_o(err_valid_o), .err_code_o(err_code_o),
        .err_core_o(err_core_o), .err_first_code_o(err_first_code_o),
        .err_count_o(err_count_o), .pending_o(pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Command fields are octal: one digit per core, core 3 leftmost.
    function automatic stim_t mk_s(input logic [11:0] m, input logic [3:0] a,
                                   input logic [11:0] c);
        stim_t s;
        s.rst = 1'b0; s.clr = 1'b0; s.mcmd = m;
        s.maddr = '0; s.mack = a; s.ccmd = c;
        return s;
    endfunction

    function automatic logic [21:0] mk_e(input logic v, input logic [2:0] code,
        input logic [2:0] core, input logic [2:0] first, input logic [7:0] cnt,
        input logic [3:0] pend);
        return {v, code, core, first, cnt, pend};
    endfunction

    function automatic logic [21:0] obs();
        return {err_valid_o, err_code_o, err_core_o,
                err_first_code_o, err_count_o, pending_o};
    endfunction

    task automatic drive(input stim_t s);
        rst = s.rst; clear_i = s.clr; mbus_cmd_i = s.mcmd;
        mbus_addr_i = s.maddr; mbus_ack_i = s.mack; cbus_cmd_i = s.ccmd;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        stim_t s;
        s = mk_s(0, 0, 0);
        s.rst = 1'b1;
        drive(s);
    endtask

    task automatic test_reset();
        stim_t s; logic [21:0] e, g;
        s = mk_s(12'o7777, 4'hF, 12'o7777); s.rst = 1'b1;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        s = mk_s(0, 0, 0);
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_broadcast();
        stim_t s; logic [21:0] e, g;
        do_reset();
        s = mk_s(12'o0003, 0, 0); s.maddr[31:0] = 32'd1;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0001));
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0001));
        s.mack = 4'b0001;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0001));
        for (int k = 0; k < 2; k++) begin
            sq.push_back(mk_s(0, 0, 0));
            exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0001));
        end
        sq.push_back(mk_s(0, 0, 12'o0003)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(mk_s(0, 0, 0));        exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(mk_s(12'o0400, 4'b0100, 0));
        exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0100));
        sq.push_back(mk_s(0, 0, 12'o0400)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL broadcast[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_conflict();
        stim_t s; logic [21:0] e, g;
        do_reset();
        s = mk_s(12'o0011, 0, 0); s.maddr[0 +: 32] = 6; s.maddr[32 +: 32] = 6;
        sq.push_back(s); exp_q.push_back(mk_e(1, 4, 1, 4, 1, 0));
        s.maddr[32 +: 32] = 7;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 4, 1, 0));
        s = mk_s(12'o2020, 0, 0); s.maddr[32 +: 32] = 9; s.maddr[96 +: 32] = 9;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 4, 1, 0));
        s = mk_s(12'o1100, 0, 0); s.maddr[64 +: 32] = 32'h55; s.maddr[96 +: 32] = 32'h55;
        sq.push_back(s); exp_q.push_back(mk_e(1, 4, 3, 4, 2, 0));
        s = mk_s(12'o0111, 0, 0);
        s.maddr[0 +: 32] = 32'hA; s.maddr[32 +: 32] = 32'hA; s.maddr[64 +: 32] = 32'hA;
        sq.push_back(s); exp_q.push_back(mk_e(1, 4, 1, 4, 3, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL conflict[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_priority();
        logic [21:0] e, g;
        do_reset();
        sq.push_back(mk_s(12'o0070, 0, 12'o0400)); exp_q.push_back(mk_e(1, 1, 1, 1, 1, 0));
        sq.push_back(mk_s(12'o5000, 0, 12'o0005)); exp_q.push_back(mk_e(1, 2, 0, 1, 2, 0));
        sq.push_back(mk_s(12'o0005, 0, 12'o0006)); exp_q.push_back(mk_e(1, 1, 0, 1, 3, 0));
        sq.push_back(mk_s(0, 0, 0));               exp_q.push_back(mk_e(0, 0, 0, 1, 3, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL priority[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [21:0] e, g;
        do_reset();
        sq.push_back(mk_s(12'o0040, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0010));
`ifdef MESI_ISC_MON_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            sq.push_back(mk_s(0, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0010));
        end
        sq.push_back(mk_s(0, 0, 0)); exp_q.push_back(mk_e(1, 5, 1, 5, 1, 0));
        sq.push_back(mk_s(0, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 5, 1, 0));
`else
        for (int k = 1; k < 13; k++) begin
            sq.push_back(mk_s(0, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0010));
        end
        sq.push_back(mk_s(0, 4'b0010, 0)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0010));
        sq.push_back(mk_s(0, 0, 12'o0040)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
`endif
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL timeout[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_ack_stuck();
        stim_t s; logic [21:0] e, g; int cnt;
        do_reset();
        sq.push_back(mk_s(0, 4'b0001, 0)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(mk_s(0, 4'b0001, 0)); exp_q.push_back(mk_e(1, 3, 0, 3, 1, 0));
        sq.push_back(mk_s(0, 4'b0001, 0)); exp_q.push_back(mk_e(1, 3, 0, 3, 2, 0));
        sq.push_back(mk_s(0, 0, 0));       exp_q.push_back(mk_e(0, 0, 0, 3, 2, 0));
        sq.push_back(mk_s(0, 4'b0001, 0)); exp_q.push_back(mk_e(0, 0, 0, 3, 2, 0));
        cnt = 2;
        for (int k = 1; k <= 300; k++) begin
            cnt = (cnt < 255) ? cnt + 1 : 255;
            sq.push_back(mk_s(0, 4'b0001, 0));
            exp_q.push_back(mk_e(1, 3, 0, 3, 8'(cnt), 0));
        end
        sq.push_back(mk_s(0, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 3, 255, 0));
        s = mk_s(0, 0, 0); s.clr = 1'b1;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(mk_s(0, 4'b0001, 0)); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(mk_s(0, 4'b0001, 0)); exp_q.push_back(mk_e(1, 3, 0, 3, 1, 0));
        s = mk_s(0, 4'b0001, 0); s.clr = 1'b1;
        sq.push_back(s); exp_q.push_back(mk_e(1, 3, 0, 3, 1, 0));
        sq.push_back(mk_s(0, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 3, 1, 0));
        s = mk_s(0, 0, 0); s.clr = 1'b1;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL ack_stuck[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_rst_mid();
        stim_t s; logic [21:0] e, g;
        do_reset();
        sq.push_back(mk_s(12'o7003, 4'b0001, 0));
        exp_q.push_back(mk_e(1, 1, 3, 1, 1, 4'b0001));
        s = mk_s(0, 0, 0); s.rst = 1'b1;
        sq.push_back(s); exp_q.push_back(mk_e(0, 0, 0, 0, 0, 0));
        sq.push_back(mk_s(0, 0, 12'o0003)); exp_q.push_back(mk_e(1, 6, 0, 6, 1, 0));
        sq.push_back(mk_s(0, 0, 0));        exp_q.push_back(mk_e(0, 0, 0, 6, 1, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL rst_mid[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [21:0] e, g;
        do_reset();
        sq.push_back(mk_s(12'o0043, 4'b0010, 0));
        exp_q.push_back(mk_e(0, 0, 0, 0, 0, 4'b0011));
        sq.push_back(mk_s(0, 4'b0001, 12'o0030));
        exp_q.push_back(mk_e(1, 6, 1, 6, 1, 4'b0001));
        sq.push_back(mk_s(0, 0, 12'o0003)); exp_q.push_back(mk_e(0, 0, 0, 6, 1, 0));
        sq.push_back(mk_s(12'o0300, 0, 0)); exp_q.push_back(mk_e(0, 0, 0, 6, 1, 4'b0100));
        sq.push_back(mk_s(0, 0, 12'o0300)); exp_q.push_back(mk_e(1, 6, 2, 6, 2, 0));
        for (int i = 0; sq.size() > 0; i++) begin
            drive(sq.pop_front()); e = exp_q.pop_front(); g = obs();
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clear_i = 1'b0; mbus_cmd_i = '0; mbus_addr_i = '0;
        mbus_ack_i = '0; cbus_cmd_i = '0; cbus_ack_i = '0;
        test_reset();
        test_broadcast();
        test_conflict();
        test_priority();
        test_timeout();
        test_ack_stuck();
        test_rst_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
